// File: rtl/mips_pkg.sv
// Shared MIPS-32 definitions used by the fetch unit and control_32:
// opcode/funct constants, control encodings and fetch FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [31:0] PC_RESET_DEFAULT    = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0180;

  typedef enum logic [1:0] {
    BRANCH_NONE = 2'b00,
    BRANCH_BEQ  = 2'b01,
    BRANCH_BNE  = 2'b10,
    BRANCH_RSVD = 2'b11
  } branch_e;

  typedef enum logic [1:0] {
    JUMP_NONE = 2'b00,
    JUMP_J    = 2'b01,
    JUMP_JAL  = 2'b10,
    JUMP_JR   = 2'b11
  } jump_e;

  typedef enum logic [1:0] {
    RST_S = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10
  } fetch_state_e;

  // Sign-extended word offset of a branch immediate.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_32_if.sv
// Instruction-memory req/ack bus between the fetch unit and instruction memory.
interface fetch_unit_32_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit_32_next_pc.sv
// next_pc_32: combinational next-PC / trap selection for the instruction in EXEC.
module next_pc_32
  import mips_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT
) (
  input  logic [31:0] i_pc_plus4,
  input  logic [25:0] i_instr_index,
  input  logic [1:0]  i_branch,
  input  logic [1:0]  i_jump,
  input  logic        i_err_illegal_opcode,
  input  logic        i_zero,
  input  logic [31:0] i_jr_target,
  output logic [31:0] o_next_pc,
  output logic        o_trap
);

  logic        w_take;
  logic [31:0] w_branch_target;

  // Reserved branch code 11 falls through as "no branch".
  assign w_take = ((i_branch == BRANCH_BEQ) &&  i_zero) ||
                  ((i_branch == BRANCH_BNE) && !i_zero);
  assign w_branch_target = i_pc_plus4 + branch_offset(i_instr_index[15:0]);

  always_comb begin
    o_next_pc = i_pc_plus4;
    o_trap    = 1'b0;
    if (i_err_illegal_opcode) begin
      o_next_pc = TRAP_VECTOR;
      o_trap    = 1'b1;
    end else if (i_jump == JUMP_JR) begin
      if (i_jr_target[1:0] != 2'b00) begin
        o_next_pc = TRAP_VECTOR;
        o_trap    = 1'b1;
      end else begin
        o_next_pc = i_jr_target;
      end
    end else if ((i_jump == JUMP_J) || (i_jump == JUMP_JAL)) begin
      o_next_pc = {i_pc_plus4[31:28], i_instr_index, 2'b00};
    end else if (w_take) begin
      o_next_pc = w_branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit_32.sv
// Instruction-side sequencer: owns the PC and IR, fetches over req/ack,
// presents decoded fields to control_32 and selects the next PC.
module fetch_unit_32
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET    = PC_RESET_DEFAULT,
  parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_unit_32_if.master        imem,
  output logic [5:0]             opcode,
  output logic [5:0]             funct,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [4:0]             rd,
  output logic [15:0]            imm,
  output logic                   instr_valid,
  input  logic [1:0]             branch,
  input  logic [1:0]             jump,
  input  logic                   err_illegal_opcode,
  input  logic                   zero,
  input  logic [31:0]            jr_target,
  input  logic                   stall,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic                   trap
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_ir;
  logic         r_req;
  logic         r_valid;
  logic [31:0]  w_next_pc;
  logic         w_trap_req;

  next_pc_32 #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next_pc (
    .i_pc_plus4           (pc_plus4),
    .i_instr_index        (r_ir[25:0]),
    .i_branch             (branch),
    .i_jump               (jump),
    .i_err_illegal_opcode (err_illegal_opcode),
    .i_zero               (zero),
    .i_jr_target          (jr_target),
    .o_next_pc            (w_next_pc),
    .o_trap               (w_trap_req)
  );

  // r_req and r_valid mirror FETCH/EXEC so the bus outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_S;
      r_pc    <= PC_RESET;
      r_ir    <= '0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        RST_S: begin
          r_state <= FETCH;
          r_req   <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_ack) begin
            r_ir    <= imem.imem_rdata;
            r_state <= EXEC;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall) begin
            r_pc    <= w_next_pc;
            r_state <= FETCH;
            r_req   <= 1'b1;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= RST_S;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_pc;

  assign opcode      = r_ir[31:26];
  assign rs          = r_ir[25:21];
  assign rt          = r_ir[20:16];
  assign rd          = r_ir[15:11];
  assign imm         = r_ir[15:0];
  assign funct       = r_ir[5:0];
  assign instr_valid = r_valid;

  assign pc       = r_pc;
  assign pc_plus4 = r_pc + 32'd4;
  // Only the leaving EXEC cycle redirects, so a stalled trap still pulses once.
  assign trap     = r_valid & ~stall & w_trap_req;

endmodule

// File: tb/tb_fetch_unit_32.sv
// Scoreboard bench for fetch_unit_32 with a behavioural next-PC reference model.
module tb_fetch_unit_32;

  localparam logic [31:0] PC_RST = 32'h0000_0000;
  localparam logic [31:0] TRAPV  = 32'h0000_0180;

  logic        clk = 1'b0;
  logic        rst;
  logic        ack;
  logic [31:0] rdata;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        instr_valid;
  logic [1:0]  br, jp;
  logic        err, z, stall;
  logic [31:0] jrt;
  logic [31:0] pc, pc_plus4;
  logic        trap;

  always #5 clk = ~clk;

  fetch_unit_32_if bus ();
  assign bus.imem_ack   = ack;
  assign bus.imem_rdata = rdata;

  fetch_unit_32 #(
    .PC_RESET    (PC_RST),
    .TRAP_VECTOR (TRAPV)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .imem               (bus.master),
    .opcode             (opcode),
    .funct              (funct),
    .rs                 (rs),
    .rt                 (rt),
    .rd                 (rd),
    .imm                (imm),
    .instr_valid        (instr_valid),
    .branch             (br),
    .jump               (jp),
    .err_illegal_opcode (err),
    .zero               (z),
    .jr_target          (jrt),
    .stall              (stall),
    .pc                 (pc),
    .pc_plus4           (pc_plus4),
    .trap               (trap)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        trap;
  } exec_t;

  exec_t       exp_exec[$];
  logic [31:0] exp_addr[$];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned trap_cnt = 0;
  logic [31:0] m_pc;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  // Reference next PC straight from the architectural rules.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                           input logic [1:0] b, input logic [1:0] j,
                                           input logic e, input logic zf,
                                           input logic [31:0] tgt, output logic tr);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(word[15:0]));
    tr  = 1'b0;
    if (e || (j == 2'd3 && (tgt % 4) != 0)) begin
      tr = 1'b1;
      return TRAPV;
    end
    if (j == 2'd3) return tgt;
    if (j == 2'd1 || j == 2'd2)
      return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    if ((b == 2'd1 && zf) || (b == 2'd2 && !zf)) return seq + 32'(off * 4);
    return seq;
  endfunction

  task automatic do_instr(input logic [31:0] word, input logic [1:0] b, input logic [1:0] j,
                          input logic e, input logic zf, input logic [31:0] tgt,
                          input int unsigned delay, input int unsigned stalls);
    int unsigned t;
    logic        tr;
    logic [31:0] nxt;
    t = 0;
    while (!bus.imem_req) begin
      if (t == 20) begin
        n_chk++;
        n_fail++;
        $display("FAIL fetch_req_timeout: got req=0 for %0d cycles expected req=1", t);
        finish_test();
      end
      @(posedge clk);
      #1;
      t++;
    end
    repeat (delay) begin
      stall = 1'($urandom_range(1));
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    br = b; jp = j; err = e; z = zf; jrt = tgt;
    nxt = ref_next(m_pc, word, b, j, e, zf, tgt, tr);
    exp_addr.push_back(m_pc);
    exp_exec.push_back('{pc: m_pc, word: word, trap: tr});
    ack = 1'b1;
    rdata = word;
    @(posedge clk);
    #1;
    ack = 1'b0;
    repeat (stalls) begin
      stall = 1'b1;
      ack = 1'($urandom_range(1));
      rdata = $urandom;
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    ack = 1'($urandom_range(1));
    @(posedge clk);
    #1;
    ack = 1'b0;
    m_pc = nxt;
  endtask

  // Monitor: checks every accepted fetch and every EXEC cycle against the queues.
  always @(negedge clk) begin
    exec_t e;
    if (!rst) begin
      if (bus.imem_req && ack) begin
        if (exp_addr.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_fetch: got addr %h expected no fetch", bus.imem_addr);
        end else begin
          chk("imem_addr", bus.imem_addr, exp_addr.pop_front());
        end
      end
      if (instr_valid) begin
        if (exp_exec.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_exec: got pc %h expected no EXEC", pc);
        end else begin
          e = exp_exec[0];
          chk("exec_pc", pc, e.pc);
          chk("pc_plus4", pc_plus4, e.pc + 32'd4);
          chk("opcode", {26'd0, opcode}, {26'd0, e.word[31:26]});
          chk("rs", {27'd0, rs}, {27'd0, e.word[25:21]});
          chk("rt", {27'd0, rt}, {27'd0, e.word[20:16]});
          chk("rd", {27'd0, rd}, {27'd0, e.word[15:11]});
          chk("imm", {16'd0, imm}, {16'd0, e.word[15:0]});
          chk("funct", {26'd0, funct}, {26'd0, e.word[5:0]});
          chk("trap", {31'd0, trap}, {31'd0, e.trap & ~stall});
          if (!stall) void'(exp_exec.pop_front());
        end
      end else begin
        chk("trap_idle", {31'd0, trap}, 32'd0);
      end
      if (trap) trap_cnt++;
    end
  end

  initial begin
    #200000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected test completion");
    finish_test();
  end

  initial begin
    int unsigned t0, tc;
    logic [31:0] w, tg;
    logic [1:0]  rb, rj;
    rst = 1'b1; ack = 1'b0; rdata = '0; br = '0; jp = '0;
    err = 1'b0; z = 1'b0; jrt = '0; stall = 1'b0;
    m_pc = PC_RST;
    #12;
    chk("rst_pc", pc, PC_RST);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_ir", {26'd0, opcode}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #4;
    chk("rst_s_req", {31'd0, bus.imem_req}, 32'd0);

    // Sequential words, ack in the first FETCH cycle
    do_instr(32'h2008_0001, 2'd0, 2'd0, 1'b0, 1'b0, 32'd0, 0, 0);
    chk("seq_pc1", pc, 32'h4);
    t0 = cyc;
    do_instr(32'h2009_0002, 2'd0, 2'd0, 1'b0, 1'b0, 32'd0, 0, 0);
    do_instr(32'h012A_5820, 2'd0, 2'd0, 1'b0, 1'b0, 32'd0, 0, 0);
    chk("throughput_cycles", cyc - t0, 32'd4);
    chk("seq_pc3", pc, 32'hC);

    // Branches around 0x40
    do_instr(32'h0000_0008, 2'd0, 2'd3, 1'b0, 1'b0, 32'h40, 1, 0);
    do_instr(32'h1000_FFFF, 2'd1, 2'd0, 1'b0, 1'b1, 32'd0, 0, 0);
    chk("beq_taken", pc, 32'h40);
    do_instr(32'h1400_0003, 2'd2, 2'd0, 1'b0, 1'b0, 32'd0, 0, 1);
    chk("bne_taken", pc, 32'h50);
    do_instr(32'h0000_0008, 2'd0, 2'd3, 1'b0, 1'b0, 32'h40, 0, 0);
    do_instr(32'h1000_FFFF, 2'd1, 2'd0, 1'b0, 1'b0, 32'd0, 0, 0);
    chk("beq_not_taken", pc, 32'h44);

    // j / jal within the current 256 MB region
    do_instr(32'h0000_0008, 2'd0, 2'd3, 1'b0, 1'b0, 32'h1000_0000, 0, 0);
    do_instr(32'h0800_0010, 2'd0, 2'd1, 1'b0, 1'b0, 32'd0, 2, 0);
    chk("j_target", pc, 32'h1000_0040);
    do_instr(32'h0000_0008, 2'd0, 2'd3, 1'b0, 1'b0, 32'h1000_0000, 0, 0);
    do_instr(32'h0C00_0010, 2'd0, 2'd2, 1'b0, 1'b0, 32'd0, 0, 2);
    chk("jal_target", pc, 32'h1000_0040);

    // jr aligned and misaligned
    do_instr(32'h0000_0008, 2'd0, 2'd3, 1'b0, 1'b0, 32'h2000, 0, 0);
    chk("jr_target", pc, 32'h2000);
    tc = trap_cnt;
    do_instr(32'h0000_0008, 2'd0, 2'd3, 1'b0, 1'b0, 32'h2002, 0, 0);
    chk("jr_misaligned_pc", pc, TRAPV);
    chk("jr_misaligned_pulses", trap_cnt - tc, 32'd1);

    // Illegal opcode held in EXEC by stall
    tc = trap_cnt;
    do_instr(32'hFC00_0000, 2'd0, 2'd0, 1'b1, 1'b0, 32'd0, 0, 3);
    chk("illegal_pc", pc, TRAPV);
    chk("illegal_pulses", trap_cnt - tc, 32'd1);

    // PC wraps modulo 2^32
    do_instr(32'h0000_0008, 2'd0, 2'd3, 1'b0, 1'b0, 32'hFFFF_FFFC, 0, 0);
    do_instr(32'h2008_0001, 2'd0, 2'd0, 1'b0, 1'b0, 32'd0, 0, 0);
    chk("pc_wrap", pc, 32'h0);

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      w  = $urandom;
      rb = 2'($urandom_range(3));
      rj = ($urandom_range(1) == 0) ? 2'd0 : 2'($urandom_range(3));
      tg = $urandom;
      if ($urandom_range(3) != 0) tg[1:0] = 2'b00;
      do_instr(w, rb, rj, ($urandom_range(7) == 0), 1'($urandom_range(1)), tg,
               $urandom_range(3), $urandom_range(2));
    end

    // Reset in the middle of a long FETCH, with a stale ack afterwards
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midfetch_req_drop", {31'd0, bus.imem_req}, 32'd0);
    chk("midfetch_pc", pc, PC_RST);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ack = 1'b1;
    rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    ack = 1'b0;
    chk("post_rst_req", {31'd0, bus.imem_req}, 32'd1);
    chk("post_rst_stale_ack", {31'd0, instr_valid}, 32'd0);
    chk("post_rst_pc", pc, PC_RST);
    m_pc = PC_RST;
    do_instr(32'h2008_0001, 2'd0, 2'd0, 1'b0, 1'b0, 32'd0, 0, 0);
    chk("post_rst_next", pc, 32'h4);

    repeat (3) @(posedge clk);
    #1;
    chk("exec_queue_empty", exp_exec.size(), 32'd0);
    chk("addr_queue_empty", exp_addr.size(), 32'd0);
    finish_test();
  end

endmodule

// File: doc/fetch_unit_32.md
Name: fetch_unit_32

Overview:
- Instruction-side sequencer for the 32-bit MIPS core; it is the producer of the opcode/funct that control_32 decodes.
- Owns the PC and fetches instruction words from instruction memory over a req/ack handshake.
- Splits each word into fields and presents them to control_32, then consumes control_32's branch/jump/error outputs plus the ALU zero flag to select the next PC.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0180, PC loaded on an illegal opcode or a misaligned jr target.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  32  fetch address (equals pc while req is high).
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  32  instruction word.
- opcode  out  6  IR[31:26], to control_32.
- funct  out  6  IR[5:0], to control_32.
- rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11].
- imm  out  16  IR[15:0].
- instr_valid  out  1  high while the decoded fields are being executed (EXEC state).
- branch  in  2  from control: 00 none, 01 beq, 10 bne, 11 reserved (treated as none).
- jump  in  2  from control: 00 none, 01 j, 10 jal, 11 jr.
- err_illegal_opcode  in  1  from control.
- zero  in  1  ALU zero flag.
- jr_target  in  32  register-file rs value.
- stall  in  1  datapath hold request.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc+4, used as the jal link value.
- trap  out  1  one-cycle pulse when redirecting to TRAP_VECTOR.

Behaviour:
- States: RST_S, FETCH, EXEC.
- Reset (asynchronous) values:
  - state=RST_S, pc=PC_RESET, IR=0.
  - imem_req=0, instr_valid=0, trap=0.
- RST_S: unconditionally moves to FETCH on the next clock.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - On the edge where imem_ack=1: IR<=imem_rdata, state<=EXEC.
  - imem_ack outside FETCH is ignored.
- EXEC:
  - instr_valid=1; fields are driven combinationally from IR.
  - While stall=1: remain in EXEC with pc and IR unchanged.
  - When stall=0, on the edge: pc<=next_pc, state<=FETCH.
- next_pc priority, highest first:
  1. err_illegal_opcode -> TRAP_VECTOR, trap=1.
  2. jump=11 with jr_target[1:0]!=0 -> TRAP_VECTOR, trap=1.
  3. jump=11 -> jr_target.
  4. jump=01 or 10 -> {pc_plus4[31:28], IR[25:0], 2'b00}.
  5. (branch=01 and zero=1) or (branch=10 and zero=0) -> pc_plus4 + ({{14{imm[15]}}, imm, 2'b00}).
  6. Otherwise -> pc_plus4.
- Arithmetic: all PC additions are modulo 2^32. pc=32'hFFFF_FFFC gives pc_plus4=0.
- trap is asserted only in the cycle EXEC leaves with stall=0, so it pulses exactly once per trapping instruction.
- pc_plus4 is combinational pc+4 and is valid in every state.
- Throughput: a minimum of 2 cycles per instruction (ack in the first FETCH cycle, then 1 EXEC cycle).
- Reset asserted mid-FETCH: imem_req drops immediately (asynchronously). A late imem_ack after reset release is ignored because the block is in RST_S.
- Reset mid-EXEC: the instruction is abandoned and pc=PC_RESET.
- stall during FETCH is ignored; it only affects EXEC.

Decomposition:
- Shared package mips_pkg holds:
  - Opcode constants (r_type, lw, sw, beq, bne, addi, j, jal) and jr_func, common with control_32.
  - BRANCH_NONE/BEQ/BNE and JUMP_NONE/J/JAL/JR encodings.
  - FSM state typedef and default vectors.
- One sub-module, next_pc_32: combinational next_pc/trap selection.
- FSM, PC register and IR live in fetch_unit_32.

Test Plan:
1. Reset, memory acks every FETCH at the same cycle; sequential non-branch words -> imem_addr 0, 4, 8, one EXEC per 2 cycles, trap=0.
2. pc=0x40, beq imm=0xFFFF: zero=1 -> next pc=0x40; zero=0 -> next pc=0x44. bne imm=3 with zero=0 -> next pc=0x50.
3. pc=0x1000_0000, j target 0x0000010 -> next pc=0x1000_0040. jal gives the same pc and pc_plus4=0x1000_0004 during EXEC.
4. jr with jr_target=0x0000_2000 -> next pc=0x2000. jr_target=0x2002 -> pc=0x180 and trap pulses for 1 cycle.
5. err_illegal_opcode=1 (opcode 6'b111111) -> pc=TRAP_VECTOR, trap 1 cycle. stall held 3 cycles in EXEC -> pc/IR frozen and trap still a single pulse.
6. ack delayed 4 cycles with rst asserted in the 2nd wait cycle -> imem_req=0 immediately. After release, RST_S then FETCH at PC_RESET, and the stale ack is ignored.
